alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: serialises one operation at a time onto a multi-cycle ALU datapath.
// Optional macro ALU_SEQ_PERF_EN builds the perf_ops/perf_mul counters; undefined, both read 0.
module alu_seq_ctrl #(
  parameter int unsigned MUL_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  input  logic [31:0] alu_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic [15:0] perf_ops,
  output logic [15:0] perf_mul
);

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  localparam logic [7:0] MUL_CNT_INIT = 8'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_WAIT,
    S_RESP
  } state_t;

  function automatic logic is_single_cycle(input logic [5:0] f);
    logic r;
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO: r = 1'b1;
      default:                                                 r = 1'b0;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        busy_q, busy_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [5:0]  alu_signal_q, alu_signal_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        accept;

  // req_ready_q is only ever high in IDLE, so accept implies an IDLE transfer
  assign accept = req_valid && req_ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    alu_signal_d = alu_signal_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_funct == F_MULTU) begin
            state_d      = S_MUL_WAIT;
            cnt_d        = MUL_CNT_INIT;
            alu_signal_d = req_funct;
            alu_a_d      = req_a;
            alu_b_d      = req_b;
          end else if (is_single_cycle(req_funct)) begin
            state_d      = S_EXEC;
            alu_signal_d = req_funct;
            alu_a_d      = req_a;
            alu_b_d      = req_b;
          end else begin
            // illegal code: skip the datapath entirely
            state_d     = S_RESP;
            resp_data_d = 32'd0;
            resp_err_d  = 1'b1;
          end
        end
      end
      S_EXEC: begin
        state_d      = S_RESP;
        resp_data_d  = alu_result;
        resp_err_d   = 1'b0;
        alu_signal_d = 6'd0;
        alu_a_d      = 32'd0;
        alu_b_d      = 32'd0;
      end
      S_MUL_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d      = S_RESP;
          resp_data_d  = 32'd0;
          resp_err_d   = 1'b0;
          alu_signal_d = 6'd0;
          alu_a_d      = 32'd0;
          alu_b_d      = 32'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d     = S_IDLE;
          resp_data_d = 32'd0;
          resp_err_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      resp_data_q  <= 32'd0;
      alu_signal_q <= 6'd0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      resp_data_q  <= resp_data_d;
      alu_signal_q <= alu_signal_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign alu_signal = alu_signal_q;
  assign alu_dataA  = alu_a_q;
  assign alu_dataB  = alu_b_q;

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_ops_q, perf_ops_d;
  logic [15:0] perf_mul_q, perf_mul_d;

  // both counters wrap naturally at 16 bits
  always_comb begin
    perf_ops_d = perf_ops_q;
    perf_mul_d = perf_mul_q;
    if (accept) begin
      perf_ops_d = perf_ops_q + 16'd1;
      if (req_funct == F_MULTU) perf_mul_d = perf_mul_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q <= 16'd0;
      perf_mul_q <= 16'd0;
    end else begin
      perf_ops_q <= perf_ops_d;
      perf_mul_q <= perf_mul_d;
    end
  end

  assign perf_ops = perf_ops_q;
  assign perf_mul = perf_mul_q;
`else
  assign perf_ops = 16'd0;
  assign perf_mul = 16'd0;
`endif

endmodule
